gather_dat: RTL and testbench
=============================

// Module: gather_dat
// PURPOSE
//  Inverse of the datapath chunk funnel: accepts narrow CHUNK_W-bit beats on a
//  req/ack stream and packs them, LSB chunk first, into one wide word.
//  Sits between the narrow initiator-side lanes and a wide target consumer.
//  A 1-deep output register lets filling of word k+1 overlap the drain of word k.
// PARAMETERS
//  CHUNK_W  32  bits per narrow beat (radix 1 complex: 2 x 16)
//  CHUNKS    4  max beats per wide word; power of two, 2..16
//  WIDE_W  CHUNKS*CHUNK_W  wide word width (derived, not overridable)
// PORTS
//  clk        in   1        single clock; everything sampled on rising edge
//  reset_n    in   1        reset, synchronous, active-low
//  t_cfg_dat  in   8        [2:0]=log2 beats/word (clamped to log2 CHUNKS); [7:3] ignored
//  t_0_dat    in   CHUNK_W  narrow beat data
//  t_0_req    in   1        beat valid
//  t_0_last   in   1        beat closes word early (qualified by t_0_req)
//  t_0_ack    out  1        beat accepted this cycle when t_0_req & t_0_ack
//  i_0_dat    out  WIDE_W   packed word (registered)
//  i_0_req    out  1        wide word valid
//  i_0_ack    in   1        consumer takes word when i_0_req & i_0_ack
//  mode       out  8        active config {5'b0, log2 beats} latched at word start
//  fill       out  5        beats held in current partial word
// BEHAVIOUR
//  - Clock/reset: one clock; reset synchronous, active-low. While reset_n=0 at a
//    clk edge: fill=0, i_0_req=0, i_0_dat=0, accumulator=0, mode=log2(CHUNKS).
//    Mid-word reset discards the partial word and any held output word.
//  - N = 1<<mode. mode reloads from t_cfg_dat only on a cycle where fill==0;
//    cfg changes mid-word are ignored until the word closes.
//  - Handshake: beat transfers iff t_0_req & t_0_ack; word transfers iff
//    i_0_req & i_0_ack. req never drops, data never changes, until the transfer.
//  - Beat k (k=fill) is written to acc[k*CHUNK_W +: CHUNK_W]; fill increments.
//  - Close: accepted beat with fill==N-1 or t_0_last=1. On close the word
//    {acc with beat merged, unwritten chunks forced 0} loads i_0_dat,
//    i_0_req=1 next cycle; fill and acc clear same edge (1-cycle latency).
//  - Upper chunks at index >= N are always 0 in i_0_dat.
//  - t_0_ack = ~(closing_beat & i_0_req & ~i_0_ack): non-closing beats always
//    accepted; a closing beat stalls only while the held word is undrained.
//    Simultaneous drain + close in one cycle is legal: new word replaces old,
//    i_0_req stays 1 (sustained 1 beat/clk throughput).
//  - States (implicit): FILL (fill<N-1, out any), CLOSE_WAIT (closing beat
//    pending, out held). CLOSE_WAIT -> FILL on i_0_ack.
//  - t_0_last with fill==0 yields a word with only chunk 0 populated.
//  - fill wraps 0 after close; no overflow possible (fill max N-1).
// TESTING
//  1 Reset, cfg=2, beats 0x11,0x22,0x33,0x44 back-to-back, i_0_ack=1 ->
//    i_0_req 1 cyc after 4th beat, i_0_dat=0x00000044_00000033_00000022_00000011.
//  2 cfg=1 (N=2), 6 beats, i_0_ack=1 -> 3 words, upper 2 chunks 0, no t_0_ack gaps.
//  3 i_0_ack=0, stream 8 beats N=4 -> word 1 held, t_0_ack drops on beat 8 only;
//    raise i_0_ack -> beat 8 accepted same cycle, word 2 valid next cycle.
//  4 t_0_last on 2nd beat (N=4) -> word = {0,0,b1,b0}; fill returns 0.
//  5 cfg change 2->1 after 1st beat -> current word still 4 beats; next word 2.
//  6 reset_n=0 for 1 cyc after 3 beats with held word -> i_0_req=0, fill=0,
//    next 4 beats form clean word with no stale data.

Source files
------------

// File: rtl/gather_dat.sv
// Narrow-to-wide stream packer: collects CHUNK_W-bit beats LSB-first into one
// wide word, with a 1-deep output register so the next word can fill during drain.
module gather_dat #(
  parameter int CHUNK_W = 32,
  parameter int CHUNKS  = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [7:0]                t_cfg_dat,
  input  logic [CHUNK_W-1:0]        t_0_dat,
  input  logic                      t_0_req,
  input  logic                      t_0_last,
  output logic                      t_0_ack,
  output logic [CHUNKS*CHUNK_W-1:0] i_0_dat,
  output logic                      i_0_req,
  input  logic                      i_0_ack,
  output logic [7:0]                mode,
  output logic [4:0]                fill
);

  localparam int WIDE_W = CHUNKS * CHUNK_W;
  localparam int LOG2C  = $clog2(CHUNKS);
  localparam logic [2:0] LOG2C_V = 3'(LOG2C);

  logic [WIDE_W-1:0] accR;
  logic [WIDE_W-1:0] iDatR;
  logic [WIDE_W-1:0] mergedS;
  logic [4:0]        fillR;
  logic [4:0]        lastIdxS;
  logic [2:0]        modeR;
  logic [2:0]        cfgModeS;
  logic [2:0]        curModeS;
  logic              iReqR;
  logic              closingS;
  logic              ackS;
  logic              beatXferS;
  logic              drainS;
  logic              unusedCfgS;

  assign unusedCfgS = ^t_cfg_dat[7:3];

  // Effective word length and the close/stall decision for the offered beat.
  // At a word boundary the fresh config already governs the first beat.
  always_comb begin
    cfgModeS = t_cfg_dat[2:0];
    curModeS = modeR;
    if (t_cfg_dat[2:0] > LOG2C_V) begin
      cfgModeS = LOG2C_V;
    end else begin
      cfgModeS = t_cfg_dat[2:0];
    end
    if (fillR == 5'd0) begin
      curModeS = cfgModeS;
    end else begin
      curModeS = modeR;
    end
    lastIdxS  = (5'd1 << curModeS) - 5'd1;
    closingS  = t_0_req & (t_0_last | (fillR == lastIdxS));
    ackS      = ~(closingS & iReqR & ~i_0_ack);
    beatXferS = t_0_req & ackS;
    drainS    = iReqR & i_0_ack;
  end

  // Merge the incoming beat at slot fill; slots above it are forced to zero.
  always_comb begin
    mergedS = accR;
    for (int k = 0; k < CHUNKS; k++) begin
      if (5'(k) == fillR) begin
        mergedS[k*CHUNK_W +: CHUNK_W] = t_0_dat;
      end else if (5'(k) > fillR) begin
        mergedS[k*CHUNK_W +: CHUNK_W] = '0;
      end else begin
        mergedS[k*CHUNK_W +: CHUNK_W] = accR[k*CHUNK_W +: CHUNK_W];
      end
    end
  end

  // Accumulator, fill count, latched mode and the held output word.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      accR  <= '0;
      iDatR <= '0;
      iReqR <= 1'b0;
      fillR <= 5'd0;
      modeR <= LOG2C_V;
    end else begin
      if (fillR == 5'd0) begin
        modeR <= cfgModeS;
      end else begin
        modeR <= modeR;
      end
      if (beatXferS && closingS) begin
        iDatR <= mergedS;
        accR  <= '0;
        fillR <= 5'd0;
      end else if (beatXferS) begin
        accR  <= mergedS;
        fillR <= fillR + 5'd1;
      end else begin
        accR  <= accR;
        fillR <= fillR;
      end
      // A close in the same cycle as a drain replaces the word without a bubble.
      if (beatXferS && closingS) begin
        iReqR <= 1'b1;
      end else if (drainS) begin
        iReqR <= 1'b0;
      end else begin
        iReqR <= iReqR;
      end
    end
  end

  assign t_0_ack = ackS;
  assign i_0_dat = iDatR;
  assign i_0_req = iReqR;
  assign mode    = {5'b0, modeR};
  assign fill    = fillR;

endmodule

// File: tb/tb_gather_dat.sv
// Bench for gather_dat: directed scenarios plus a randomized run against a
// queue-based word-assembly model.
module tb_gather_dat;

  logic         clk = 1'b0;
  logic         rstN;
  logic [7:0]   cfg;
  logic [31:0]  tDat;
  logic         tReq;
  logic         tLast;
  logic         tAck;
  logic [127:0] iDat;
  logic         iReq;
  logic         iAck;
  logic [7:0]   modeO;
  logic [4:0]   fillO;

  int total = 0;
  int bad   = 0;

  // Reference model: beats of the open word, held output word, latched mode.
  bit [31:0]  pend[$];
  int         mMode = 2;
  bit         mHeld = 1'b0;
  bit [127:0] mWord = '0;

  gather_dat dut (
    .clk(clk), .reset_n(rstN), .t_cfg_dat(cfg),
    .t_0_dat(tDat), .t_0_req(tReq), .t_0_last(tLast), .t_0_ack(tAck),
    .i_0_dat(iDat), .i_0_req(iReq), .i_0_ack(iAck),
    .mode(modeO), .fill(fillO)
  );

  always #5 clk = ~clk;

  function automatic int clampCfg(input logic [7:0] c);
    return (c[2:0] > 3'd2) ? 2 : int'(c[2:0]);
  endfunction

  function automatic bit predClose();
    int n;
    n = (pend.size() == 0) ? (1 << clampCfg(cfg)) : (1 << mMode);
    return tReq && (tLast || pend.size() == n - 1);
  endfunction

  function automatic bit predAck();
    return !(predClose() && mHeld && !iAck);
  endfunction

  task automatic drive(input bit r, input logic [31:0] d, input bit l);
    tReq = r; tDat = d; tLast = l;
  endtask

  task automatic tick();
    bit cl, ak;
    bit [127:0] w;
    cl = predClose();
    ak = predAck();
    @(posedge clk);
    if (!rstN) begin
      pend.delete(); mHeld = 1'b0; mWord = '0; mMode = 2;
    end else begin
      if (pend.size() == 0) mMode = clampCfg(cfg);
      if (tReq && ak) begin
        pend.push_back(tDat);
        if (cl) begin
          w = '0;
          foreach (pend[i]) w[i*32 +: 32] = pend[i];
          mWord = w; mHeld = 1'b1; pend.delete();
        end else if (mHeld && iAck) begin
          mHeld = 1'b0;
        end
      end else if (mHeld && iAck) begin
        mHeld = 1'b0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rstN = 1'b0; cfg = 8'd2; iAck = 1'b1; drive(1'b0, 32'h0, 1'b0);
    tick(); tick();
    total++; if (iReq !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", iReq); end
    total++; if (fillO !== 5'd0) begin bad++; $display("FAIL reset_fill got=%0d exp=0", fillO); end
    total++; if (iDat !== 128'h0) begin bad++; $display("FAIL reset_dat got=%h exp=0", iDat); end
    total++; if (modeO !== 8'd2) begin bad++; $display("FAIL reset_mode got=%0d exp=2", modeO); end
    total++; if (tAck !== 1'b1) begin bad++; $display("FAIL reset_ack got=%b exp=1", tAck); end
    rstN = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    cfg = 8'd2; iAck = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h11 * (i + 1), 1'b0);
      #1;
      total++; if (tAck !== 1'b1) begin bad++; $display("FAIL basic_ack beat=%0d got=%b exp=1", i, tAck); end
      tick();
      if (i < 3) begin
        total++; if (iReq !== 1'b0 || fillO !== 5'(i + 1)) begin
          bad++; $display("FAIL basic_fill beat=%0d req=%b fill=%0d exp req=0 fill=%0d", i, iReq, fillO, i + 1);
        end
      end else begin
        total++; if (iReq !== 1'b1) begin bad++; $display("FAIL basic_req got=%b exp=1", iReq); end
        total++; if (iDat !== 128'h00000044_00000033_00000022_00000011) begin
          bad++; $display("FAIL basic_dat got=%h exp=00000044000000330000002200000011", iDat);
        end
        total++; if (fillO !== 5'd0) begin bad++; $display("FAIL basic_wrap got=%0d exp=0", fillO); end
      end
    end
    drive(1'b0, 32'h0, 1'b0);
    tick();
    total++; if (iReq !== 1'b0) begin bad++; $display("FAIL basic_drain got=%b exp=0", iReq); end
  endtask

  task automatic test_n2();
    bit [31:0] b[6];
    cfg = 8'd1; iAck = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b[i] = $urandom;
      drive(1'b1, b[i], 1'b0);
      #1;
      total++; if (tAck !== 1'b1) begin bad++; $display("FAIL n2_ack beat=%0d got=%b exp=1", i, tAck); end
      tick();
      total++; if (fillO !== 5'(i % 2 == 0 ? 1 : 0)) begin
        bad++; $display("FAIL n2_fill beat=%0d got=%0d exp=%0d", i, fillO, (i % 2 == 0) ? 1 : 0);
      end
      if (i % 2 == 1) begin
        total++; if (iReq !== 1'b1 || iDat !== {64'h0, b[i], b[i-1]}) begin
          bad++; $display("FAIL n2_word beat=%0d req=%b got=%h exp=%h", i, iReq, iDat, {64'h0, b[i], b[i-1]});
        end
      end
    end
    total++; if (modeO !== 8'd1) begin bad++; $display("FAIL n2_mode got=%0d exp=1", modeO); end
    drive(1'b0, 32'h0, 1'b0);
    tick();
  endtask

  task automatic test_stall();
    bit [31:0] b[8];
    cfg = 8'd2; iAck = 1'b0;
    for (int i = 0; i < 8; i++) begin
      b[i] = $urandom;
      drive(1'b1, b[i], 1'b0);
      #1;
      total++; if (tAck !== (i == 7 ? 1'b0 : 1'b1)) begin
        bad++; $display("FAIL stall_ack beat=%0d got=%b exp=%b", i, tAck, (i == 7) ? 1'b0 : 1'b1);
      end
      if (i < 7) tick();
    end
    tick();
    total++; if (fillO !== 5'd3 || iReq !== 1'b1) begin
      bad++; $display("FAIL stall_hold fill=%0d req=%b exp fill=3 req=1", fillO, iReq);
    end
    total++; if (iDat !== {b[3], b[2], b[1], b[0]}) begin
      bad++; $display("FAIL stall_word1 got=%h exp=%h", iDat, {b[3], b[2], b[1], b[0]});
    end
    iAck = 1'b1;
    #1;
    total++; if (tAck !== 1'b1) begin bad++; $display("FAIL stall_release got=%b exp=1", tAck); end
    tick();
    total++; if (iReq !== 1'b1 || iDat !== {b[7], b[6], b[5], b[4]} || fillO !== 5'd0) begin
      bad++; $display("FAIL stall_word2 req=%b fill=%0d got=%h exp=%h", iReq, fillO, iDat, {b[7], b[6], b[5], b[4]});
    end
    drive(1'b0, 32'h0, 1'b0);
    tick();
    total++; if (iReq !== 1'b0) begin bad++; $display("FAIL stall_drain got=%b exp=0", iReq); end
  endtask

  task automatic test_last();
    bit [31:0] b0, b1, b2;
    cfg = 8'd2; iAck = 1'b1;
    b0 = $urandom; b1 = $urandom; b2 = $urandom;
    drive(1'b1, b0, 1'b0); tick();
    drive(1'b1, b1, 1'b1); tick();
    total++; if (iReq !== 1'b1 || iDat !== {64'h0, b1, b0} || fillO !== 5'd0) begin
      bad++; $display("FAIL last_early req=%b fill=%0d got=%h exp=%h", iReq, fillO, iDat, {64'h0, b1, b0});
    end
    drive(1'b1, b2, 1'b1); tick();
    total++; if (iDat !== {96'h0, b2}) begin
      bad++; $display("FAIL last_single got=%h exp=%h", iDat, {96'h0, b2});
    end
    drive(1'b0, 32'h0, 1'b0); tick();
  endtask

  task automatic test_cfg_change();
    bit [31:0] a[6];
    cfg = 8'd2; iAck = 1'b1;
    for (int i = 0; i < 6; i++) a[i] = $urandom;
    drive(1'b1, a[0], 1'b0); tick();
    total++; if (modeO !== 8'd2) begin bad++; $display("FAIL cfg_mode_first got=%0d exp=2", modeO); end
    cfg = 8'd1;
    for (int i = 1; i < 4; i++) begin
      drive(1'b1, a[i], 1'b0); tick();
    end
    total++; if (iReq !== 1'b1 || iDat !== {a[3], a[2], a[1], a[0]}) begin
      bad++; $display("FAIL cfg_old_word req=%b got=%h exp=%h", iReq, iDat, {a[3], a[2], a[1], a[0]});
    end
    drive(1'b1, a[4], 1'b0); tick();
    total++; if (modeO !== 8'd1 || fillO !== 5'd1) begin
      bad++; $display("FAIL cfg_mode_new mode=%0d fill=%0d exp mode=1 fill=1", modeO, fillO);
    end
    drive(1'b1, a[5], 1'b0); tick();
    total++; if (iDat !== {64'h0, a[5], a[4]}) begin
      bad++; $display("FAIL cfg_new_word got=%h exp=%h", iDat, {64'h0, a[5], a[4]});
    end
    drive(1'b0, 32'h0, 1'b0); tick();
  endtask

  task automatic test_reset_mid();
    bit [31:0] c[4];
    cfg = 8'd2; iAck = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, $urandom, 1'b0); tick();
    end
    drive(1'b0, 32'h0, 1'b0);
    rstN = 1'b0; tick(); rstN = 1'b1;
    total++; if (iReq !== 1'b0 || fillO !== 5'd0 || iDat !== 128'h0) begin
      bad++; $display("FAIL midrst_clear req=%b fill=%0d dat=%h exp 0/0/0", iReq, fillO, iDat);
    end
    iAck = 1'b1;
    for (int i = 0; i < 4; i++) begin
      c[i] = $urandom;
      drive(1'b1, c[i], 1'b0); tick();
    end
    total++; if (iReq !== 1'b1 || iDat !== {c[3], c[2], c[1], c[0]}) begin
      bad++; $display("FAIL midrst_word req=%b got=%h exp=%h", iReq, iDat, {c[3], c[2], c[1], c[0]});
    end
    drive(1'b0, 32'h0, 1'b0); tick();
  endtask

  task automatic test_random();
    bit stalled;
    bit expAck;
    stalled = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!stalled) drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 7) == 0);
      iAck = $urandom_range(0, 2) != 0;
      if ($urandom_range(0, 15) == 0) cfg = 8'($urandom_range(0, 255));
      rstN = $urandom_range(0, 99) != 0;
      #1;
      expAck = predAck();
      total++; if (tAck !== expAck) begin bad++; $display("FAIL rand_ack cyc=%0d got=%b exp=%b", n, tAck, expAck); end
      stalled = rstN && tReq && !expAck;
      tick();
      total++; if (iReq !== mHeld || iDat !== mWord) begin
        bad++; $display("FAIL rand_out cyc=%0d req=%b dat=%h exp req=%b dat=%h", n, iReq, iDat, mHeld, mWord);
      end
      total++; if (fillO !== 5'(pend.size()) || modeO !== 8'(mMode)) begin
        bad++; $display("FAIL rand_state cyc=%0d fill=%0d mode=%0d exp fill=%0d mode=%0d", n, fillO, modeO, pend.size(), mMode);
      end
    end
    rstN = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_n2();
    test_stall();
    test_last();
    test_cfg_change();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
